// File: rtl/pio_timer.sv
// Parametrised I/O-and-timer block: NPORTS bidirectional ports, a prescaled
// interval timer and a port-0 MSB edge interrupt, all on phi2.
module pio_timer #(
    parameter int NPORTS  = 2,
    parameter int PORT_W  = 8,
    parameter int TIMER_W = 8
) (
    input  logic                     phi2,
    input  logic                     rst,
    input  logic                     cs,
    input  logic                     we_n,
    input  logic [4:0]               A,
    input  logic [PORT_W-1:0]        DI,
    output logic [PORT_W-1:0]        DO,
    output logic                     OE,
    input  logic [NPORTS*PORT_W-1:0] pi,
    output logic [NPORTS*PORT_W-1:0] po,
    output logic [NPORTS*PORT_W-1:0] ddr,
    output logic                     irq
);

    logic [TIMER_W-1:0] count;
    logic [9:0]         prescaler;
    logic [9:0]         div_m1;
    logic [1:0]         div_sel;
    logic               tflag, fast, tie;
    logic               eflag, eie, epol;
    logic               prev, prev_valid;
    logic               tick, underflow, edge_seen;
    logic               wr, rd;
    logic               port_sel, timer_sel, stat_sel, ectl_sel;
    logic [PORT_W-1:0]  rd_data;

    assign wr        = cs & ~we_n;
    assign rd        = cs & we_n;
    assign OE        = rd;
    assign port_sel  = ~A[4];
    assign timer_sel = (A[4:3] == 2'b10);
    assign stat_sel  = (A[4:3] == 2'b11) && (A[1:0] == 2'b00);
    assign ectl_sel  = (A[4:3] == 2'b11) && (A[1:0] == 2'b01);

    always_comb begin
        case (div_sel)
            2'b00:   div_m1 = 10'd0;
            2'b01:   div_m1 = 10'd7;
            2'b10:   div_m1 = 10'd63;
            default: div_m1 = 10'd1023;
        endcase
    end

    // After an underflow the timer ticks every cycle until software reloads or reads it.
    assign tick      = fast | (prescaler == div_m1);
    assign underflow = tick & (count == '0);
    assign edge_seen = epol ? (~prev & pi[PORT_W-1]) : (prev & ~pi[PORT_W-1]);
    assign irq       = (tflag & tie) | (eflag & eie);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rd_data = '0;
        if (port_sel) begin
            for (int p = 0; p < NPORTS; p++) begin
                if (A[3:1] == 3'(p)) begin
                    rd_data = A[0] ? ddr[p*PORT_W +: PORT_W]
                                   : (po[p*PORT_W +: PORT_W] & ddr[p*PORT_W +: PORT_W]) |
                                     (pi[p*PORT_W +: PORT_W] & ~ddr[p*PORT_W +: PORT_W]);
                end
            end
        end else if (timer_sel) begin
            rd_data = PORT_W'(count);
        end else if (stat_sel) begin
            rd_data[1:0] = {eflag, tflag};
        end else if (ectl_sel) begin
            rd_data[1:0] = {epol, eie};
        end
    end

    assign DO = rd_data;

    always_ff @(posedge phi2) begin
        if (rst) begin
            po         <= '0;
            ddr        <= '0;
            count      <= '0;
            prescaler  <= '0;
            div_sel    <= 2'b00;
            tflag      <= 1'b0;
            fast       <= 1'b0;
            tie        <= 1'b0;
            eflag      <= 1'b0;
            eie        <= 1'b0;
            epol       <= 1'b0;
            prev       <= 1'b0;
            prev_valid <= 1'b0;
        end else begin
            prev       <= pi[PORT_W-1];
            prev_valid <= 1'b1;

            if (tick) begin
                prescaler <= '0;
                count     <= count - 1'b1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end

            // NOTE: non-blocking assignments later in this block override earlier ones,
            // so the statement order below encodes the collision priorities.
            if (rd && timer_sel) begin
                tflag <= 1'b0;
                fast  <= 1'b0;
                tie   <= A[2];
            end
            if (underflow) begin
                tflag <= 1'b1;
                fast  <= 1'b1;
            end

            if (rd && stat_sel)
                eflag <= 1'b0;
            if (prev_valid && edge_seen)
                eflag <= 1'b1;

            if (wr) begin
                if (port_sel) begin
                    for (int p = 0; p < NPORTS; p++) begin
                        if (A[3:1] == 3'(p)) begin
                            if (A[0]) ddr[p*PORT_W +: PORT_W] <= DI;
                            else      po[p*PORT_W +: PORT_W]  <= DI;
                        end
                    end
                end
                if (timer_sel) begin
                    count     <= DI[TIMER_W-1:0];
                    div_sel   <= A[1:0];
                    tie       <= A[2];
                    prescaler <= '0;
                    tflag     <= 1'b0;
                    fast      <= 1'b0;
                end
                if (ectl_sel) begin
                    eie  <= DI[0];
                    epol <= DI[1];
                end
            end
        end
    end

endmodule

// File: tb/tb_pio_timer.sv
// Directed bench for pio_timer: ports, timer countdown/underflow, collisions,
// edge interrupt and mid-count reset, with hand-computed expectations.
module tb_pio_timer;

    logic        phi2 = 1'b0;
    logic        rst, cs, we_n;
    logic [4:0]  A;
    logic [7:0]  DI, DO;
    logic        OE, irq;
    logic [15:0] pi, po, ddr;
    logic [7:0]  d;
    int          n_cmp = 0;
    int          n_bad = 0;

    pio_timer #(.NPORTS(2), .PORT_W(8), .TIMER_W(8)) dut (
        .phi2(phi2), .rst(rst), .cs(cs), .we_n(we_n), .A(A), .DI(DI), .DO(DO),
        .OE(OE), .pi(pi), .po(po), .ddr(ddr), .irq(irq)
    );

    always #5 phi2 = ~phi2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled there too.
    task automatic cycle();
        @(posedge phi2);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic bus_write(input logic [4:0] addr, input logic [7:0] data);
        cs = 1'b1; we_n = 1'b0; A = addr; DI = data;
        cycle();
        cs = 1'b0; we_n = 1'b1;
    endtask

    task automatic bus_read(input logic [4:0] addr, output logic [7:0] data);
        cs = 1'b1; we_n = 1'b1; A = addr;
        #1;
        data = DO;
        cycle();
        cs = 1'b0;
    endtask

    // DO depends only on A and state, so a deselected peek has no side effects.
    task automatic peek_chk(input string tag, input logic [4:0] addr, input logic [7:0] exp);
        A = addr;
        #1;
        check(tag, DO, exp);
    endtask

    initial begin
        rst = 1'b1; cs = 1'b0; we_n = 1'b1; A = 5'b00000; DI = 8'h00;
        pi = 16'h005A;
        idle(3);
        check("rst_po", po, 16'h0000);
        check("rst_ddr", ddr, 16'h0000);
        check("rst_irq", irq, 1'b0);
        check("rst_oe", OE, 1'b0);
        peek_chk("rst_port_read_pi", 5'b00000, 8'h5A);
        rst = 1'b0;
        cycle();

        // Ports: mixed direction read-back
        pi[15:8] = 8'h3C;
        bus_write(5'b00011, 8'hF0);
        bus_write(5'b00010, 8'hA5);
        check("po_p1", po[15:8], 8'hA5);
        check("ddr_p1", ddr[15:8], 8'hF0);
        cs = 1'b1; we_n = 1'b1; A = 5'b00010;
        #1;
        check("oe_read", OE, 1'b1);
        check("p1_read_mix", DO, 8'hAC);
        cycle();
        cs = 1'b0;
        bus_read(5'b00100, d);
        check("p_nports_read", d, 8'h00);
        check("irq_idle", irq, 1'b0);

        // Timer: divide 8, tie=1, N=3
        bus_write(5'b10101, 8'h03);
        peek_chk("t_load", 5'b10101, 8'h03);
        idle(8);
        peek_chk("t_edge8", 5'b10101, 8'h02);
        idle(8);
        peek_chk("t_edge16", 5'b10101, 8'h01);
        idle(8);
        peek_chk("t_edge24", 5'b10101, 8'h00);
        idle(7);
        peek_chk("t_edge31", 5'b10101, 8'h00);
        check("irq_edge31", irq, 1'b0);
        idle(1);
        peek_chk("t_edge32_wrap", 5'b10101, 8'hFF);
        check("irq_edge32", irq, 1'b1);
        peek_chk("stat_edge32", 5'b11000, 8'h01);
        idle(1);
        peek_chk("t_edge33_fast", 5'b10101, 8'hFE);
        bus_read(5'b10101, d);
        check("t_read_val", d, 8'hFE);
        check("irq_after_tread", irq, 1'b0);
        peek_chk("t_edge34", 5'b10101, 8'hFD);
        idle(7);
        peek_chk("t_div8_hold", 5'b10101, 8'hFD);
        idle(1);
        peek_chk("t_div8_tick", 5'b10101, 8'hFC);

        // Timer N=0, divide 1, tie=0
        bus_write(5'b10000, 8'h00);
        peek_chk("t0_load", 5'b10000, 8'h00);
        idle(1);
        peek_chk("t0_wrap", 5'b10000, 8'hFF);
        check("irq_tie0", irq, 1'b0);
        bus_read(5'b11000, d);
        check("stat_tflag", d, 8'h01);

        // Underflow coinciding with a timer read: set wins
        bus_write(5'b10000, 8'h00);
        bus_read(5'b10000, d);
        check("t_rd_coll_val", d, 8'h00);
        peek_chk("stat_rd_coll", 5'b11000, 8'h01);
        peek_chk("t_rd_coll_cnt", 5'b10000, 8'hFF);

        // Underflow coinciding with a timer write: write wins
        bus_write(5'b10000, 8'h00);
        bus_write(5'b10000, 8'h05);
        peek_chk("t_wr_coll_cnt", 5'b10000, 8'h05);
        peek_chk("stat_wr_coll", 5'b11000, 8'h00);

        // Park the timer far from underflow, then edge interrupt
        bus_write(5'b10011, 8'hFF);
        bus_write(5'b11001, 8'h03);
        peek_chk("ectl_read", 5'b11001, 8'h03);
        pi[7] = 1'b1;
        peek_chk("edge_before", 5'b11000, 8'h00);
        check("irq_edge_before", irq, 1'b0);
        cycle();
        check("irq_edge", irq, 1'b1);
        peek_chk("stat_edge", 5'b11000, 8'h02);
        bus_read(5'b11000, d);
        check("stat_edge_read", d, 8'h02);
        peek_chk("stat_edge_clr", 5'b11000, 8'h00);
        check("irq_edge_clr", irq, 1'b0);
        pi[7] = 1'b0;
        idle(2);
        peek_chk("stat_fall_ignored", 5'b11000, 8'h00);

        // Reset mid-count with a concurrent port-0 write and pi MSB high
        bus_write(5'b10001, 8'h50);
        bus_write(5'b00001, 8'hFF);
        idle(3);
        pi[7] = 1'b1;
        rst = 1'b1; cs = 1'b1; we_n = 1'b0; A = 5'b00000; DI = 8'h77;
        cycle();
        rst = 1'b0; cs = 1'b0; we_n = 1'b1;
        check("mrst_po", po, 16'h0000);
        check("mrst_ddr", ddr, 16'h0000);
        check("mrst_irq", irq, 1'b0);
        peek_chk("mrst_timer", 5'b10000, 8'h00);
        peek_chk("mrst_stat", 5'b11000, 8'h00);
        peek_chk("mrst_ectl", 5'b11001, 8'h00);
        cycle();
        // count=0 with divide 1 underflows on the first edge; no eflag appears
        peek_chk("post_rst_stat", 5'b11000, 8'h01);
        peek_chk("post_rst_timer", 5'b10000, 8'hFF);
        cycle();
        peek_chk("post_rst_stat2", 5'b11000, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
